// File: rtl/clkmon_pkg.sv
// Shared types and helpers for the clock period monitor.
package clkmon_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        MEAS    = 3'd2,
        LOCKED  = 3'd3,
        STOPPED = 3'd4
    } state_t;

    localparam int ERR_W = 8;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/clkmon_sync.sv
// Two-flop synchronizer for the monitored clock plus a history flop for edge detection.
module clkmon_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic mon_clk,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period of an asynchronous clock in clk cycles and reports lock/range/stop.
// Optional duty-cycle check (high_time) enabled by defining CLKMON_DUTY_EN.
module clk_period_monitor
    import clkmon_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int EXP_PERIOD = 10,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mon_clk,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             in_range,
    output logic             locked,
    output logic             stopped,
    output logic [ERR_W-1:0] err_cnt,
    output logic [CNT_W-1:0] high_time
);

    localparam int               LO_I   = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
    localparam logic [CNT_W-1:0] LO     = CNT_W'(LO_I);
    localparam logic [CNT_W-1:0] HI     = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
    localparam int               GW     = $clog2(LOCK_CNT + 1) + 1;
    localparam logic [GW-1:0]    LOCK_C = GW'(LOCK_CNT);

    logic level;
    logic rise;
    logic fall;

    clkmon_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .mon_clk (mon_clk),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GW-1:0]    good_q, good_d;
    logic [CNT_W-1:0] period_d;
    logic             vld_d;
    logic             in_range_d;
    logic             locked_d;
    logic             stopped_d;
    logic [ERR_W-1:0] err_d;
    logic             duty_ok;
    logic             meas_ok;
    logic             timeout;

`ifdef CLKMON_DUTY_EN
    localparam int               HLO_I = (EXP_PERIOD / 2 > TOL) ? EXP_PERIOD / 2 - TOL : 0;
    localparam logic [CNT_W-1:0] HLO   = CNT_W'(HLO_I);
    localparam logic [CNT_W-1:0] HHI   = CNT_W'(EXP_PERIOD / 2 + TOL);

    logic [CNT_W-1:0] hcnt_q;

    // High phase counted in the synchronized domain; captured on the falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt_q    <= '0;
            high_time <= '0;
        end else begin
            if (rise)
                hcnt_q <= CNT_W'(1);
            else if (level && hcnt_q != '1)
                hcnt_q <= hcnt_q + 1'b1;
            if (fall)
                high_time <= hcnt_q;
        end
    end

    assign duty_ok = (high_time >= HLO) && (high_time <= HHI);
`else
    logic unused_sync;

    assign unused_sync = level ^ fall;
    assign high_time   = '0;
    assign duty_ok     = 1'b1;
`endif

    assign meas_ok = (cnt_q >= LO) && (cnt_q <= HI) && duty_ok;
    assign timeout = (cnt_q == TMO);

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        good_d     = good_q;
        period_d   = period;
        vld_d      = 1'b0;
        in_range_d = in_range;
        locked_d   = locked;
        stopped_d  = stopped;
        err_d      = err_cnt;

        if (rise)
            cnt_d = CNT_W'(1);

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en)
                    state_d = ARM;
            end
            // The interval before the first rise is unknown, so it is never reported.
            ARM: begin
                if (rise) begin
                    state_d = MEAS;
                end else if (timeout) begin
                    state_d   = STOPPED;
                    stopped_d = 1'b1;
                    locked_d  = 1'b0;
                    good_d    = '0;
                end
            end
            MEAS, LOCKED: begin
                if (rise) begin
                    vld_d      = 1'b1;
                    period_d   = cnt_q;
                    in_range_d = meas_ok;
                    if (meas_ok) begin
                        if (state_q == MEAS) begin
                            if (good_q + 1'b1 >= LOCK_C) begin
                                state_d  = LOCKED;
                                locked_d = 1'b1;
                                good_d   = LOCK_C;
                            end else begin
                                good_d = good_q + 1'b1;
                            end
                        end
                    end else begin
                        good_d   = '0;
                        err_d    = sat_inc(err_cnt);
                        locked_d = 1'b0;
                        state_d  = MEAS;
                    end
                end else if (timeout) begin
                    state_d   = STOPPED;
                    stopped_d = 1'b1;
                    locked_d  = 1'b0;
                    good_d    = '0;
                end
            end
            STOPPED: begin
                if (rise) begin
                    state_d   = MEAS;
                    stopped_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable overrides everything; period and err_cnt deliberately hold.
        if (!en) begin
            state_d    = IDLE;
            cnt_d      = '0;
            good_d     = '0;
            vld_d      = 1'b0;
            in_range_d = 1'b0;
            locked_d   = 1'b0;
            stopped_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            good_q     <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            in_range   <= 1'b0;
            locked     <= 1'b0;
            stopped    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            good_q     <= good_d;
            period     <= period_d;
            period_vld <= vld_d;
            in_range   <= in_range_d;
            locked     <= locked_d;
            stopped    <= stopped_d;
            err_cnt    <= err_d;
        end
    end

endmodule

// File: tb/tb_clk_period_monitor.sv
// Scoreboard bench for clk_period_monitor: randomized mon_clk periods against an interval-based model.
module tb_clk_period_monitor;

    localparam int EXP   = 10;
    localparam int TOL   = 1;
    localparam int LOCKN = 4;
    localparam int TMO   = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        mon_clk = 1'b0;
    logic [15:0] period;
    logic        period_vld;
    logic        in_range;
    logic        locked;
    logic        stopped;
    logic [7:0]  err_cnt;
    logic [15:0] high_time;

    clk_period_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .mon_clk    (mon_clk),
        .period     (period),
        .period_vld (period_vld),
        .in_range   (in_range),
        .locked     (locked),
        .stopped    (stopped),
        .err_cnt    (err_cnt),
        .high_time  (high_time)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [15:0] period;
        logic        in_range;
        logic        locked;
        logic [7:0]  err;
    } exp_t;

    exp_t sb[$];

    // Reference model: works purely on the intervals between driven mon_clk rises.
    bit armed      = 1'b0;
    int last_rise  = 0;
    int m_good     = 0;
    bit m_locked   = 1'b0;
    int m_err      = 0;
    int m_period   = 0;
    int last_vld_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_rise(input int c);
        int p;
        bit ok;
        if (!armed) begin
            armed     = 1'b1;
            last_rise = c;
            return;
        end
        p = c - last_rise;
        last_rise = c;
        if (p > TMO) begin
            m_good   = 0;
            m_locked = 1'b0;
            return;
        end
        ok = (p - EXP <= TOL) && (EXP - p <= TOL);
        if (ok) begin
            m_good++;
            if (m_good >= LOCKN)
                m_locked = 1'b1;
        end else begin
            m_good   = 0;
            m_locked = 1'b0;
            if (m_err < 255)
                m_err++;
        end
        m_period = p;
        sb.push_back(exp_t'{period: 16'(p), in_range: ok, locked: m_locked, err: 8'(m_err)});
    endfunction

    function automatic void model_reset(input bit keep_err);
        armed    = 1'b0;
        m_good   = 0;
        m_locked = 1'b0;
        if (!keep_err) begin
            m_err    = 0;
            m_period = 0;
        end
    endfunction

    // Monitor: every period_vld pulse must match the oldest expected measurement.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && period_vld) begin
            last_vld_cyc = cyc;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_vld: period_vld=1 with period=%0d, required no pulse", period);
            end else begin
                e = sb.pop_front();
                check("vld_period",   32'(period),   32'(e.period));
                check("vld_in_range", 32'(in_range), 32'(e.in_range));
                check("vld_locked",   32'(locked),   32'(e.locked));
                check("vld_err_cnt",  32'(err_cnt),  32'(e.err));
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic mon_rise();
        mon_clk = 1'b1;
        model_rise(cyc);
    endtask

    // Called at posedge+2; returns at posedge+2 exactly p cycles after the rise.
    task automatic run_period(input int p);
        mon_rise();
        repeat (p / 2) @(posedge clk);
        #2 mon_clk = 1'b0;
        repeat (p - p / 2) @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},    32'(period),     0);
        check({tag, "_vld"},       32'(period_vld), 0);
        check({tag, "_in_range"},  32'(in_range),   0);
        check({tag, "_locked"},    32'(locked),     0);
        check({tag, "_stopped"},   32'(stopped),    0);
        check({tag, "_err_cnt"},   32'(err_cnt),    0);
        check({tag, "_high_time"}, 32'(high_time),  0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;
        en    = 1'b1;
        idle_cycles(4);

        // Acquire lock on nominal period
        repeat (6) run_period(10);
        check("lock_acquired", 32'(locked), 1);

        // Single bad period, then re-lock
        run_period(13);
        repeat (5) run_period(10);
        check("relock", 32'(locked), 1);
        check("err_after_bad", 32'(err_cnt), 1);

        // Tolerance edges
        run_period(11);
        run_period(12);
        run_period(9);
        run_period(8);
        run_period(10);

        // Randomized periods around nominal
        for (int i = 0; i < 40; i++)
            run_period(int'($urandom_range(8, 12)));

        // Stopped clock
        repeat (6) run_period(10);
        mon_rise();
        repeat (5) @(posedge clk);
        #2 mon_clk = 1'b0;
        t = 0;
        while (stopped !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("stop_seen", 32'(t < 300), 1);
        check("stop_latency", 32'(cyc - last_vld_cyc), 32'(TMO));
        check("stop_locked", 32'(locked), 0);
        @(posedge clk);
        #2;
        run_period(10);
        check("stop_cleared", 32'(stopped), 0);
        repeat (7) run_period(10);
        check("lock_after_stop", 32'(locked), 32'(m_locked));

        // Enable dropped while locked
        en = 1'b0;
        model_reset(1'b1);
        idle_cycles(5);
        check("en_locked",   32'(locked),   0);
        check("en_in_range", 32'(in_range), 0);
        check("en_stopped",  32'(stopped),  0);
        check("en_err_hold", 32'(err_cnt),  32'(m_err));
        check("en_period_hold", 32'(period), 32'(m_period));
        en = 1'b1;
        idle_cycles(3);
        repeat (6) run_period(10);

        // Error counter saturation
        repeat (260) run_period(5);
        check("err_saturated", 32'(err_cnt), 255);
        repeat (6) run_period(10);
        check("lock_before_rst", 32'(locked), 1);

        // Asynchronous reset mid-operation
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        check("sb_empty_at_rst", 32'(sb.size()), 0);
        sb.delete();
        model_reset(1'b0);
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(3);
        repeat (6) run_period(10);
        check("reacquire_locked", 32'(locked), 1);
        check("reacquire_err", 32'(err_cnt), 0);

        idle_cycles(10);
        check("sb_drained", 32'(sb.size()), 0);
        check("high_time_tied", 32'(high_time), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
